// File: rtl/fifo_snapshot_ctrl_pkg.sv
// Shared definitions for the FIFO snapshot sequencer and its shadow store.
package fifo_snapshot_ctrl_pkg;

  localparam int unsigned LGFLEN_DEF = 5;
  localparam int unsigned DW_DEF     = 8;

  // Counters carry one extra bit so a completely full queue is representable.
  function automatic int unsigned cnt_w(input int unsigned lg);
    return lg + 1;
  endfunction

  localparam int unsigned CNT_W_DEF = LGFLEN_DEF + 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SCAN  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/fifo_snap_ram.sv
// Double-buffered shadow store: the back bank is written by the scan,
// the front bank is read by the renderer through a registered port.
module fifo_snap_ram
  import fifo_snapshot_ctrl_pkg::*;
#(
  parameter int unsigned LGFLEN = LGFLEN_DEF,
  parameter int unsigned DW     = DW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [LGFLEN-1:0] wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              rd_bank,
  input  logic [LGFLEN-1:0] rd_addr,
  output logic [DW-1:0]     rd_data
);

  localparam int unsigned DEPTH = 1 << LGFLEN;

  logic [DW-1:0] mem [0:2*DEPTH-1];

  // Synchronous write into the bank currently being filled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  // Registered read from the displayed bank; only the output flop is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

endmodule

// File: rtl/fifo_snapshot_ctrl.sv
// Walks the FIFO dump port from position 0, copies valid entries into the
// back bank of a shadow store, then swaps banks so the renderer always reads
// a complete, tear-free snapshot.
module fifo_snapshot_ctrl
  import fifo_snapshot_ctrl_pkg::*;
#(
  parameter int unsigned LGFLEN = LGFLEN_DEF,
  parameter int unsigned DW     = DW_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [LGFLEN-1:0] o_dmp_pos,
  input  logic [DW-1:0]     i_dmp_data,
  input  logic              i_dmp_valid,
  input  logic [LGFLEN-1:0] i_rd_pos,
  output logic [DW-1:0]     o_rd_data,
  output logic              o_rd_valid,
  output logic [LGFLEN:0]   o_count
);

  localparam int unsigned    CNT_W    = cnt_w(LGFLEN);
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(1) << LGFLEN;
  localparam logic [CNT_W-1:0] LAST   = FULL - CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] ip;
  logic [CNT_W-1:0] cp;
  logic [CNT_W-1:0] bcnt;
  logic             first;
  logic             sel;
  logic             back_sel;
  logic             capture;
  logic             wr_en;

  // Responses are captured one cycle behind issue; the first SCAN cycle has
  // no response of its own yet, so capture is held off there.
  always_comb begin
    capture  = ((state == ST_SCAN) && !first) || (state == ST_DRAIN);
    wr_en    = capture && i_dmp_valid;
    back_sel = ~sel;
  end

  // Status outputs and the dump position, decoded from state and issue counter.
  always_comb begin
    o_busy    = (state == ST_SCAN) || (state == ST_DRAIN);
    o_done    = (state == ST_DONE);
    o_dmp_pos = '0;
    if (state == ST_SCAN) begin
      o_dmp_pos = ip[LGFLEN-1:0];
    end else if (state == ST_DRAIN) begin
      o_dmp_pos = LAST[LGFLEN-1:0];
    end
  end

  // Scan sequencer: issue, capture, end-of-queue detection and bank swap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      ip      <= '0;
      cp      <= '0;
      bcnt    <= '0;
      first   <= 1'b0;
      sel     <= 1'b0;
      o_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state <= ST_SCAN;
            ip    <= '0;
            cp    <= '0;
            first <= 1'b1;
          end
        end
        ST_SCAN: begin
          first <= 1'b0;
          if (ip != LAST) begin
            ip <= ip + CNT_W'(1);
          end
          // An invalid response ends the scan even on the last-issue cycle.
          if (capture && !i_dmp_valid) begin
            bcnt  <= cp;
            state <= ST_DONE;
          end else begin
            if (capture) begin
              cp <= cp + CNT_W'(1);
            end
            if (ip == LAST) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          bcnt  <= i_dmp_valid ? FULL : cp;
          state <= ST_DONE;
        end
        ST_DONE: begin
          sel     <= ~sel;
          o_count <= bcnt;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-valid flag, aligned with the registered read data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= ({1'b0, i_rd_pos} < o_count);
    end
  end

  fifo_snap_ram #(
    .LGFLEN (LGFLEN),
    .DW     (DW)
  ) u_ram (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (wr_en),
    .wr_bank (back_sel),
    .wr_addr (cp[LGFLEN-1:0]),
    .wr_data (i_dmp_data),
    .rd_bank (sel),
    .rd_addr (i_rd_pos),
    .rd_data (o_rd_data)
  );

endmodule
